// File: rtl/rtx_pixel_stacker.sv
`default_nettype none
// ============================================================================
//  Module   : rtx_pixel_stacker
//  Purpose  : Packs the rtx raster pixel stream (RGB565 + h/v) into 128-bit,
//             8-pixel words with word address, lane mask and overwrite flag.
//             The input cannot stall: closed words are queued in a 2-entry
//             FIFO and any word that finds the FIFO full is dropped and counted.
//  Revision : 1.0 - initial release
// ============================================================================
module rtx_pixel_stacker #(
  parameter int unsigned H_RES         = 1280,
  parameter int unsigned V_RES         = 720,
  parameter int unsigned ADDR_WIDTH    = 17,
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [15:0]           in_pixel,
  input  logic [10:0]           in_h,
  input  logic [9:0]            in_v,
  input  logic                  in_overwrite,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [7:0]            out_mask,
  output logic                  out_overwrite,
  output logic                  frame_done,
  output logic [15:0]           drop_count
);

  // Pixel index needs at least 21 bits for any 10-bit row times H_RES.
  localparam int unsigned IDX_W  = (ADDR_WIDTH + 3 > 22) ? ADDR_WIDTH + 3 : 22;
  localparam int unsigned IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0]     IDLE_MAX  = IDLE_W'(FLUSH_TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_RES * V_RES / 8 - 1);

  // --------------------------------------------------------------------------
  // Stage 0: range check and address split
  // --------------------------------------------------------------------------
  logic                  in_range;
  logic                  accept;
  logic [IDX_W-1:0]      idx;

  assign in_range = (32'(in_h) < H_RES) && (32'(in_v) < V_RES);
  assign accept   = in_valid && in_range;
  assign idx      = IDX_W'(in_v) * IDX_W'(H_RES) + IDX_W'(in_h);

  logic                  s0_valid_q;
  logic [15:0]           s0_pixel_q;
  logic [ADDR_WIDTH-1:0] s0_addr_q;
  logic [2:0]            s0_lane_q;
  logic                  s0_ovw_q;

  // Capture in-range pixels; out-of-range pixels vanish here without a trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_pixel_q <= '0;
      s0_addr_q  <= '0;
      s0_lane_q  <= '0;
      s0_ovw_q   <= 1'b0;
    end else begin
      s0_valid_q <= accept;
      if (accept) begin
        s0_pixel_q <= in_pixel;
        s0_addr_q  <= ADDR_WIDTH'(idx >> 3);
        s0_lane_q  <= idx[2:0];
        s0_ovw_q   <= in_overwrite;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Idle counter: cycles since the last accepted pixel while a word is pending
  // --------------------------------------------------------------------------
  logic                  acc_open_q;
  logic [IDLE_W-1:0]     idle_q;

  // Clears on every accepted pixel, saturates at the flush threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else if (accept) begin
      idle_q <= '0;
    end else if (acc_open_q || s0_valid_q) begin
      if (idle_q != IDLE_MAX) idle_q <= idle_q + IDLE_W'(1);
    end else begin
      idle_q <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: accumulator
  // --------------------------------------------------------------------------
  logic                  acc_open_d;
  logic                  acc_full_q,  acc_full_d;
  logic [127:0]          acc_data_q,  acc_data_d;
  logic [ADDR_WIDTH-1:0] acc_addr_q,  acc_addr_d;
  logic [7:0]            acc_mask_q,  acc_mask_d;
  logic                  acc_ovw_q,   acc_ovw_d;

  logic                  push_valid_q, push_valid_d;
  logic [127:0]          push_data_q,  push_data_d;
  logic [ADDR_WIDTH-1:0] push_addr_q,  push_addr_d;
  logic [7:0]            push_mask_q,  push_mask_d;
  logic                  push_ovw_q,   push_ovw_d;

  logic                  timeout;
  logic                  close_old;
  logic                  lane7;
  logic [7:0]            lane_bit;
  logic [127:0]          ins_data;
  logic [127:0]          merge_data;
  logic [7:0]            merge_mask;
  logic                  merge_ovw;

  assign timeout    = acc_open_q && !s0_valid_q && (idle_q == IDLE_MAX);
  // acc_full_q marks a lone lane-7 word that could not be pushed in the same
  // cycle as the word it displaced; it is pushed on the following cycle.
  assign close_old  = acc_open_q &&
                      (acc_full_q || timeout || (s0_valid_q && (s0_addr_q != acc_addr_q)));
  assign lane7      = (s0_lane_q == 3'd7);
  assign lane_bit   = 8'b1 << s0_lane_q;
  assign ins_data   = 128'(s0_pixel_q) << {s0_lane_q, 4'b0000};
  assign merge_data = (acc_data_q & ~(128'hFFFF << {s0_lane_q, 4'b0000})) | ins_data;
  assign merge_mask = acc_mask_q | lane_bit;
  assign merge_ovw  = acc_ovw_q | s0_ovw_q;

  // Decide what the accumulator holds next and which word, if any, closes.
  always_comb begin
    acc_open_d   = acc_open_q;
    acc_full_d   = acc_full_q;
    acc_data_d   = acc_data_q;
    acc_addr_d   = acc_addr_q;
    acc_mask_d   = acc_mask_q;
    acc_ovw_d    = acc_ovw_q;
    push_valid_d = 1'b0;
    push_data_d  = acc_data_q;
    push_addr_d  = acc_addr_q;
    push_mask_d  = acc_mask_q;
    push_ovw_d   = acc_ovw_q;

    if (close_old) begin
      push_valid_d = 1'b1;
      acc_open_d   = 1'b0;
      acc_full_d   = 1'b0;
    end

    if (s0_valid_q) begin
      if (acc_open_q && !close_old) begin
        if (lane7) begin
          push_valid_d = 1'b1;
          push_data_d  = merge_data;
          push_mask_d  = merge_mask;
          push_ovw_d   = merge_ovw;
          acc_open_d   = 1'b0;
        end else begin
          acc_data_d = merge_data;
          acc_mask_d = merge_mask;
          acc_ovw_d  = merge_ovw;
        end
      end else if (lane7 && !close_old) begin
        push_valid_d = 1'b1;
        push_data_d  = ins_data;
        push_addr_d  = s0_addr_q;
        push_mask_d  = lane_bit;
        push_ovw_d   = s0_ovw_q;
      end else begin
        acc_open_d = 1'b1;
        acc_full_d = lane7;
        acc_data_d = ins_data;
        acc_addr_d = s0_addr_q;
        acc_mask_d = lane_bit;
        acc_ovw_d  = s0_ovw_q;
      end
    end
  end

  // Accumulator and push-staging registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_open_q   <= 1'b0;
      acc_full_q   <= 1'b0;
      acc_data_q   <= '0;
      acc_addr_q   <= '0;
      acc_mask_q   <= '0;
      acc_ovw_q    <= 1'b0;
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      push_addr_q  <= '0;
      push_mask_q  <= '0;
      push_ovw_q   <= 1'b0;
    end else begin
      acc_open_q   <= acc_open_d;
      acc_full_q   <= acc_full_d;
      acc_data_q   <= acc_data_d;
      acc_addr_q   <= acc_addr_d;
      acc_mask_q   <= acc_mask_d;
      acc_ovw_q    <= acc_ovw_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
      push_addr_q  <= push_addr_d;
      push_mask_q  <= push_mask_d;
      push_ovw_q   <= push_ovw_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO (2 entries) with drop counter and frame-end pulse
  // --------------------------------------------------------------------------
  logic [127:0]          mem_data_q [2];
  logic [ADDR_WIDTH-1:0] mem_addr_q [2];
  logic [7:0]            mem_mask_q [2];
  logic                  mem_ovw_q  [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            cnt_q;
  logic [15:0]           drop_q;
  logic                  frame_done_q;
  logic                  pop;
  logic                  room;
  logic                  push_ok;

  assign out_valid     = (cnt_q != 2'd0);
  assign out_data      = mem_data_q[rd_ptr_q];
  assign out_addr      = mem_addr_q[rd_ptr_q];
  assign out_mask      = mem_mask_q[rd_ptr_q];
  assign out_overwrite = mem_ovw_q[rd_ptr_q];
  assign frame_done    = frame_done_q;
  assign drop_count    = drop_q;

  assign pop     = out_valid && out_ready;
  // A simultaneous pop frees the slot the push lands in.
  assign room    = (cnt_q != 2'd2) || pop;
  assign push_ok = push_valid_q && room;

  // FIFO storage, pointers, occupancy, drop counting and frame-end detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_data_q[i] <= '0;
        mem_addr_q[i] <= '0;
        mem_mask_q[i] <= '0;
        mem_ovw_q[i]  <= 1'b0;
      end
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      cnt_q        <= 2'd0;
      drop_q       <= 16'd0;
      frame_done_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_data_q[wr_ptr_q] <= push_data_q;
        mem_addr_q[wr_ptr_q] <= push_addr_q;
        mem_mask_q[wr_ptr_q] <= push_mask_q;
        mem_ovw_q[wr_ptr_q]  <= push_ovw_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (push_valid_q && !room && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      frame_done_q <= pop && (out_addr == LAST_ADDR) && out_mask[7];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtx_pixel_stacker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtx_pixel_stacker
//  Purpose  : Directed self-checking bench for rtx_pixel_stacker. A word-level
//             model builds the expected word sequence from the pixel stream;
//             a per-cycle compare process checks every handshake and the
//             frame_done pulse, plus hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtx_pixel_stacker;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [15:0]  in_pixel;
  logic [10:0]  in_h;
  logic [9:0]   in_v;
  logic         in_overwrite;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [16:0]  out_addr;
  logic [7:0]   out_mask;
  logic         out_overwrite;
  logic         frame_done;
  logic [15:0]  drop_count;

  always #5 clk = ~clk;

  rtx_pixel_stacker dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_pixel      (in_pixel),
    .in_h          (in_h),
    .in_v          (in_v),
    .in_overwrite  (in_overwrite),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_addr      (out_addr),
    .out_mask      (out_mask),
    .out_overwrite (out_overwrite),
    .frame_done    (frame_done),
    .drop_count    (drop_count)
  );

  typedef struct packed {
    logic [127:0] d;
    logic [16:0]  a;
    logic [7:0]   m;
    logic         o;
  } word_t;

  word_t exp_q[$];
  word_t m_word;
  word_t cw;
  bit    m_open   = 1'b0;
  bit    bp_mode  = 1'b0;
  int    m_drops  = 0;
  int    total    = 0;
  int    bad      = 0;
  int    hs_count = 0;
  int    fd_count = 0;
  bit    fd_prev  = 1'b0;
  bit    prev_hold = 1'b0;
  logic [153:0] prev_out;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- word-level model ----------------
  function automatic void model_push(input word_t w);
    if (bp_mode && exp_q.size() >= 2) m_drops++;
    else exp_q.push_back(w);
  endfunction

  function automatic void model_pixel(input int h, input int v, input logic [15:0] p, input bit o);
    int          idx;
    int          lane;
    logic [16:0] a;
    if (h >= 1280 || v >= 720) return;
    idx  = v * 1280 + h;
    a    = 17'(idx / 8);
    lane = idx % 8;
    if (m_open && m_word.a != a) begin
      model_push(m_word);
      m_open = 1'b0;
    end
    if (!m_open) begin
      m_word   = '0;
      m_word.a = a;
      m_open   = 1'b1;
    end
    m_word.d[lane*16 +: 16] = p;
    m_word.m[lane]          = 1'b1;
    m_word.o                = m_word.o | o;
    if (lane == 7) begin
      model_push(m_word);
      m_open = 1'b0;
    end
  endfunction

  function automatic void model_flush();
    if (m_open) model_push(m_word);
    m_open = 1'b0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send(input int h, input int v, input logic [15:0] p, input bit o);
    model_pixel(h, v, p, o);
    in_valid     = 1'b1;
    in_h         = 11'(h);
    in_v         = 10'(v);
    in_pixel     = p;
    in_overwrite = o;
    @(posedge clk); #1;
    in_valid     = 1'b0;
    in_overwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      fd_prev   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("frame_done", {127'd0, frame_done}, {127'd0, fd_prev});
      if (frame_done) fd_count++;
      if (prev_hold)
        chk("head_stable", 128'({out_data, out_addr, out_mask, out_overwrite}), 128'(prev_out));
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got addr %0d expected no word", out_addr);
          fd_prev = 1'b0;
        end else begin
          cw = exp_q.pop_front();
          chk("word_data", out_data, cw.d);
          chk("word_addr", 128'(out_addr), 128'(cw.a));
          chk("word_mask", 128'(out_mask), 128'(cw.m));
          chk("word_ovw",  128'(out_overwrite), 128'(cw.o));
          fd_prev = (cw.a == 17'd115199) && cw.m[7];
        end
      end else begin
        fd_prev = 1'b0;
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_data, out_addr, out_mask, out_overwrite};
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    int hs0;
    int fd0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_pixel     = '0;
    in_h         = '0;
    in_v         = '0;
    in_overwrite = 1'b0;
    out_ready    = 1'b1;
    idle(3);

    // Reset state
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_data",  out_data, 128'd0);
    chk("rst_addr",  128'(out_addr), 128'd0);
    chk("rst_mask",  128'(out_mask), 128'd0);
    chk("rst_ovw",   128'(out_overwrite), 128'd0);
    chk("rst_fd",    128'(frame_done), 128'd0);
    chk("rst_drop",  128'(drop_count), 128'd0);
    rst = 1'b0;
    idle(2);

    // Full word: latency and literal contents
    for (int i = 0; i < 8; i++) send(i, 0, 16'(i + 1), 1'b0);
    idle(1);
    chk("full_lat_e1", 128'(out_valid), 128'd0);
    idle(1);
    chk("full_lat_e2", 128'(out_valid), 128'd1);
    chk("full_data", out_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("full_addr", 128'(out_addr), 128'd0);
    chk("full_mask", 128'(out_mask), 128'hFF);
    idle(5);

    // Address jump and idle timeout
    send(0, 0, 16'hAAAA, 1'b0);
    send(1, 0, 16'hBBBB, 1'b0);
    send(16, 0, 16'hCCCC, 1'b0);
    idle(2);
    chk("jump_valid", 128'(out_valid), 128'd1);
    chk("jump_data", out_data, 128'hBBBB_AAAA);
    chk("jump_mask", 128'(out_mask), 128'h03);
    model_flush();
    cnt = 2;
    while (cnt < 200) begin
      idle(1);
      cnt++;
      if (out_valid) break;
    end
    chk("timeout_latency", 128'(cnt), 128'd66);
    chk("timeout_addr", 128'(out_addr), 128'd2);
    chk("timeout_mask", 128'(out_mask), 128'h01);
    chk("timeout_data", out_data, 128'hCCCC);
    idle(5);

    // Backpressure: three words into a 2-deep FIFO
    out_ready = 1'b0;
    bp_mode   = 1'b1;
    for (int i = 0; i < 24; i++) send(i, 0, 16'(16'h0100 + i), 1'b0);
    idle(4);
    chk("bp_valid", 128'(out_valid), 128'd1);
    chk("bp_drop", 128'(drop_count), 128'd1);
    chk("bp_head", 128'(out_addr), 128'd0);
    chk("bp_model_drops", 128'(m_drops), 128'd1);
    bp_mode = 1'b0;
    hs0 = hs_count;
    out_ready = 1'b1;
    idle(10);
    chk("bp_drained", 128'(hs_count - hs0), 128'd2);
    chk("bp_empty", 128'(out_valid), 128'd0);

    // Frame end with lane 7, then without
    fd0 = fd_count;
    for (int h = 1272; h < 1280; h++) send(h, 719, 16'(h), 1'b0);
    idle(2);
    chk("frame_addr", 128'(out_addr), 128'd115199);
    chk("frame_mask", 128'(out_mask), 128'hFF);
    idle(1);
    chk("frame_pulse", 128'(frame_done), 128'd1);
    idle(1);
    chk("frame_pulse_end", 128'(frame_done), 128'd0);
    for (int h = 1272; h < 1279; h++) send(h, 719, 16'(h), 1'b0);
    model_flush();
    idle(80);
    chk("frame_count", 128'(fd_count - fd0), 128'd1);

    // Out-of-range pixels and overwrite flag
    hs0 = hs_count;
    send(1280, 0, 16'h1234, 1'b0);
    send(5, 720, 16'h5678, 1'b1);
    idle(80);
    chk("oor_no_word", 128'(hs_count - hs0), 128'd0);
    chk("oor_drop", 128'(drop_count), 128'd1);
    for (int h = 0; h < 8; h++) send(h, 1, 16'(16'h2000 + h), (h == 3));
    idle(2);
    chk("ovw_flag", 128'(out_overwrite), 128'd1);
    chk("ovw_addr", 128'(out_addr), 128'd160);
    idle(5);

    // New address landing on lane 7 right after an open word
    hs0 = hs_count;
    send(0, 3, 16'h3000, 1'b0);
    send(15, 3, 16'h3001, 1'b0);
    idle(8);
    chk("lane7_jump_words", 128'(hs_count - hs0), 128'd2);

    // Reset mid-word
    for (int h = 8; h < 11; h++) send(h, 2, 16'(16'h4000 + h), 1'b0);
    m_open = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    hs0 = hs_count;
    idle(100);
    chk("rst_mid_none", 128'(hs_count - hs0), 128'd0);
    for (int h = 16; h < 24; h++) send(h, 2, 16'(16'h5000 + h), 1'b0);
    idle(2);
    chk("rst_mid_valid", 128'(out_valid), 128'd1);
    chk("rst_mid_mask", 128'(out_mask), 128'hFF);

    // Drain and finish
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      idle(1);
      cnt++;
    end
    idle(2);
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rtx_pixel_stacker.md
# rtx_pixel_stacker

Packs the raster pixel stream from the `rtx` engine (16-bit RGB565 plus h/v counts, one pixel per `ray_done` pulse) into 128-bit, 8-pixel words with a word address and a per-pixel mask. It sits between `rtx` and the DRAM write path of `high_definition_frame_buffer`. `rtx` cannot stall, so the block has no input backpressure; instead it buffers output words and counts any it is forced to drop. It also flags the last word of each frame.

## Interface

Parameters:
- `H_RES`, 1280: active pixels per line.
- `V_RES`, 720: active lines per frame.
- `ADDR_WIDTH`, 17: word-address width; must satisfy 2^ADDR_WIDTH ≥ H_RES*V_RES/8.
- `FLUSH_TIMEOUT`, 64: number of idle cycles before a partial word is force-closed.

Ports:
- `clk`  in  1  the only clock, the rtx clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  pixel strobe, driven by `ray_done`.
- `in_pixel`  in  16  RGB565 pixel.
- `in_h`  in  11  pixel column.
- `in_v`  in  10  pixel row.
- `in_overwrite`  in  1  per-pixel overwrite flag.
- `out_valid`  out  1  the FIFO head word is valid.
- `out_ready`  in  1  the consumer accepts the head word.
- `out_data`  out  128  word data; lane k occupies bits [16k+15:16k].
- `out_addr`  out  ADDR_WIDTH  word address = (in_v*H_RES + in_h) >> 3.
- `out_mask`  out  8  bit k set means lane k holds a written pixel.
- `out_overwrite`  out  1  OR of `in_overwrite` over the pixels in the word.
- `frame_done`  out  1  one-cycle pulse on the handshake of the frame's final word.
- `drop_count`  out  16  number of dropped words; saturates at 0xFFFF.

## Operation

- **Stage 0 (input register):** on `in_valid`, capture the pixel and compute `idx = in_v*H_RES + in_h`, `waddr = idx>>3`, `lane = idx[2:0]`.
  - If `in_h ≥ H_RES` or `in_v ≥ V_RES`, the pixel is discarded silently. It is not counted as a drop.
- **Stage 1 (accumulator):** holds `acc_data`, `acc_addr`, `acc_mask`, `acc_ovw` and the `acc_open` flag.
  - **Accumulator closed:** open it with this pixel. Set the mask to one-hot at `lane`.
  - **Open, same address:** write the lane and set its mask bit. A repeated lane overwrites the earlier data; the later value wins.
  - **Open, different address:** close the current word and push it to the FIFO. In the same cycle, open a new word with the incoming pixel.
  - **Lane 7 written:** close the word and push it in that same cycle, including the lane-7 pixel.
  - **Idle timeout:** while the accumulator is open, an idle counter counts cycles with no stage-0 pixel. When the count reaches `FLUSH_TIMEOUT`, close and push the word. The counter clears on every accepted pixel.
- **FIFO:** 2 entries.
  - A push while full drops the pushed word and increments `drop_count` (saturating).
  - A push and a pop in the same cycle while full: the pop frees a slot, so the push is accepted.
  - `out_*` show the FIFO head and stay stable while `out_valid && !out_ready`.
- **`frame_done`:** pulses one cycle after the handshake of a word whose `out_addr` equals `H_RES*V_RES/8 − 1` and whose `out_mask[7]` is 1.
- **Arithmetic:**
  - `in_v*H_RES` uses an unsigned product wide enough to hold no overflow (≥21 bits).
  - `waddr` is truncated to `ADDR_WIDTH`.

## Timing

- **Reset values:** `out_valid`=0, `out_data`=0, `out_addr`=0, `out_mask`=0, `out_overwrite`=0, `frame_done`=0, `drop_count`=0. The accumulator is closed, the FIFO is empty and the idle counter is 0.
- **Reset mid-operation:** discards the partial word and all FIFO contents; nothing is emitted.
- **Latency:** a closing pixel sampled at edge E, with the FIFO empty, gives `out_valid`=1 after edge E+2.
  - An address-mismatch close follows the same timing: the old word's `out_valid` is high after edge E+2.
- **Timeout close:** `out_valid` is high 2 cycles after the idle counter reaches `FLUSH_TIMEOUT`, i.e. `FLUSH_TIMEOUT`+2 cycles after the last pixel's stage-0 edge.
- **Handshake:** a transfer occurs on any edge where `out_valid && out_ready`. The next head appears after that edge.
- **Throughput:** sustains 1 pixel/cycle with `out_ready`=1.

## Test plan

- **Full word:** pixels (0..7, 0) with values 0x0001..0x0008, `out_ready`=1 → one word with `out_addr`=0, `out_mask`=0xFF, `out_data`=0x0008_0007_…_0001; `out_valid` high 2 edges after the last pixel.
- **Address jump:** pixels (0,0)=0xAAAA, (1,0)=0xBBBB, then (16,0)=0xCCCC → word with addr 0, mask 0x03; the second word (addr 2, mask 0x01) appears after the timeout.
- **Backpressure:** `out_ready`=0 while 24 raster pixels arrive → `out_valid`=1, `drop_count`=1, heads at addr 0 then 1. Then raise `out_ready` → exactly 2 words drain.
- **Frame end:** pixels (1272..1279, 719) → `out_addr`=115199, mask 0xFF; `frame_done` pulses one cycle after the handshake. No pulse occurs if lane 7 is missing.
- **Out-of-range and overwrite:** a pixel at `in_h`=1280 is ignored and `drop_count` is unchanged. `in_overwrite`=1 on one pixel of a word → `out_overwrite`=1.
- **Reset mid-word:** 3 pixels then `rst` for 1 cycle → no output. The next 8-pixel word emits normally with mask 0xFF.
